// File: rtl/kmer_hash_sequencer.sv
// kmer_hash_sequencer: slides a 16-base window over a 2-bit nucleotide stream and emits one murmur hash per k-mer.
// Optional macro KMER_HASH_CANONICAL_EN hashes min(forward, reverse-complement) of each window instead of the forward chunk.

module hasher #(
  parameter int          NUM_OF_BUCKETS = 256,
  parameter logic [31:0] SEED           = 32'h8f83adef
) (
  input  logic [31:0]                       chunk,
  output logic [31:0]                       h1,
  output logic [$clog2(NUM_OF_BUCKETS)-1:0] h2
);
  localparam int          H2_W  = $clog2(NUM_OF_BUCKETS);
  localparam logic [31:0] C1    = 32'hcc9e2d51;
  localparam logic [31:0] C2    = 32'h1b873593;
  localparam logic [31:0] M_ADD = 32'he6546b64;

  logic [31:0] k_mul1;
  logic [31:0] k_rot;
  logic [31:0] k_mul2;
  logic [31:0] h_mix;
  logic [31:0] h_rot;

  // Single murmur3 block step, no finalisation mix.
  always_comb begin
    k_mul1 = chunk * C1;
    k_rot  = (k_mul1 << 15) | (k_mul1 >> 17);
    k_mul2 = k_rot * C2;
    h_mix  = SEED ^ k_mul2;
    h_rot  = (h_mix << 13) | (h_mix >> 19);
    h1     = (h_rot * 32'd5) + M_ADD;
  end

  assign h2 = h1[H2_W-1:0];

endmodule

// state    | meaning
// S_FILL   | fewer than KMER_SIZE bases of the current read are in the window
// S_STREAM | window full; every accepted base emits a k-mer hash
module kmer_hash_sequencer #(
  parameter int NUM_OF_BUCKETS = 256,
  parameter int KMER_SIZE      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_base,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [31:0]                       out_h1,
  output logic [$clog2(NUM_OF_BUCKETS)-1:0] out_h2,
  output logic [31:0]                       out_pos,
  output logic                              out_last
);
  localparam int H2_W   = $clog2(NUM_OF_BUCKETS);
  localparam int WIN_W  = 2 * KMER_SIZE;
  localparam int FILL_W = $clog2(KMER_SIZE + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(KMER_SIZE - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_cnt_next;
  logic [31:0]       pos_cnt;
  logic [31:0]       pos_cnt_next;
  logic [WIN_W-1:0]  window;
  logic [WIN_W-1:0]  window_next;
  logic              accept;
  logic              emit;
  logic [31:0]       hash_chunk;
  logic [31:0]       hash_h1;
  logic [H2_W-1:0]   hash_h2;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Oldest base sits in the top bits; each accepted base shifts in at the bottom.
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    pos_cnt_next  = pos_cnt;
    window_next   = window;
    emit          = 1'b0;
    if (accept) begin
      window_next = {window[WIN_W-3:0], in_base};
      case (state)
        S_FILL: begin
          fill_cnt_next = fill_cnt + FILL_ONE;
          if (fill_cnt == FILL_LAST) begin
            emit       = 1'b1;
            state_next = S_STREAM;
          end
        end
        S_STREAM: emit = 1'b1;
        default:  state_next = S_FILL;
      endcase
      if (emit) begin
        pos_cnt_next = pos_cnt + 32'd1;
      end
      // End of read restarts the fill whether or not a k-mer was produced.
      if (in_last) begin
        state_next    = S_FILL;
        fill_cnt_next = '0;
        pos_cnt_next  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      fill_cnt <= '0;
      pos_cnt  <= '0;
      window   <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
      pos_cnt  <= pos_cnt_next;
      window   <= window_next;
    end
  end

`ifdef KMER_HASH_CANONICAL_EN
  logic [31:0] revcomp;

  // Reverse base order and complement each base (A<->T, C<->G is a bitwise invert).
  always_comb begin
    revcomp = '0;
    for (int i = 0; i < 16; i++) begin
      revcomp[2*i +: 2] = ~window_next[30-2*i +: 2];
    end
  end

  assign hash_chunk = (revcomp < window_next[31:0]) ? revcomp : window_next[31:0];
`else
  assign hash_chunk = window_next[31:0];
`endif

  hasher #(
    .NUM_OF_BUCKETS(NUM_OF_BUCKETS)
  ) u_hasher (
    .chunk(hash_chunk),
    .h1   (hash_h1),
    .h2   (hash_h2)
  );

  // Single output register; a new emission may overwrite a result consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_h1    <= '0;
      out_h2    <= '0;
      out_pos   <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_h1    <= hash_h1;
      out_h2    <= hash_h2;
      out_pos   <= pos_cnt;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kmer_hash_sequencer.sv
// Directed bench for kmer_hash_sequencer: hand-computed constants plus a scoreboard of expected k-mers.
// Expectations follow KMER_HASH_CANONICAL_EN when the bench is built with it.

module tb_kmer_hash_sequencer;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_base;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_h1;
  logic [7:0]  out_h2;
  logic [31:0] out_pos;
  logic        out_last;

  kmer_hash_sequencer #(
    .NUM_OF_BUCKETS(256),
    .KMER_SIZE     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_base  (in_base),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_h1   (out_h1),
    .out_h2   (out_h2),
    .out_pos  (out_pos),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] h1;
    logic [31:0] pos;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n_wait = 0;
  int          stall_left = 0;
  int          out_cyc[$];
  logic [1:0]  rd[0:63];
  int          rd_len = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_h1;
  logic [31:0] hold_pos;
  logic        hold_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] murmur(input logic [31:0] c);
    logic [31:0] k;
    logic [31:0] h;
    k = c * 32'hcc9e2d51;
    k = {k[16:0], k[31:17]};
    k = k * 32'h1b873593;
    h = 32'h8f83adef ^ k;
    h = {h[18:0], h[31:19]};
    return h * 32'd5 + 32'he6546b64;
  endfunction

  function automatic logic [31:0] canon(input logic [31:0] c);
`ifdef KMER_HASH_CANONICAL_EN
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[29:0], ~c[2*i +: 2]};
    return (r < c) ? r : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [1:0] enc(input byte ch);
    case (ch)
      "A": return 2'b00;
      "C": return 2'b01;
      "G": return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic load_read(input string s);
    rd_len = s.len();
    for (int i = 0; i < rd_len; i++) rd[i] = enc(s[i]);
  endtask

  task automatic push_expected();
    exp_t        e;
    logic [31:0] c;
    for (int p = 0; p + 16 <= rd_len; p++) begin
      c = '0;
      for (int j = 0; j < 16; j++) c = {c[29:0], rd[p+j]};
      e.h1   = murmur(canon(c));
      e.pos  = 32'(p);
      e.last = (p == rd_len - 16);
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the base.
  task automatic drive_base(input logic [1:0] b, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_base  = b;
    in_last  = last;
    forever begin
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n_wait++;
      guard++;
      if (guard > 100) begin
        check_val("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic send_bases(input int n, input logic with_last, input int stall_idx);
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) stall_left = 3;
      drive_base(rd[i], with_last && (i == n - 1));
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check_val("hold_valid", 32'(out_valid), 32'd1);
        check_val("hold_h1", out_h1, hold_h1);
        check_val("hold_pos", out_pos, hold_pos);
        check_val("hold_last", 32'(out_last), 32'(hold_last));
      end
      hold_pend = out_valid && !out_ready;
      hold_h1   = out_h1;
      hold_pos  = out_pos;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("extra_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("h1", out_h1, mon_e.h1);
          check_val("h2", 32'(out_h2), 32'(mon_e.h1[7:0]));
          check_val("pos", out_pos, mon_e.pos);
          check_val("last", 32'(out_last), 32'(mon_e.last));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_base   = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_h1", out_h1, 32'd0);
    check_val("rst_h2", 32'(out_h2), 32'd0);
    check_val("rst_pos", out_pos, 32'd0);
    check_val("rst_last", 32'(out_last), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 16 x A: hashed chunk is zero in both builds.
    load_read("AAAAAAAAAAAAAAAA");
    push_expected();
    n0 = n_out;
    send_bases(16, 1'b1, -1);
    @(negedge clk);
    check_val("a16_valid", 32'(out_valid), 32'd1);
    check_val("a16_h1", out_h1, 32'h330A2514);
    check_val("a16_h2", 32'(out_h2), 32'h14);
    check_val("a16_pos", out_pos, 32'd0);
    check_val("a16_last", 32'(out_last), 32'd1);
    @(posedge clk); #1;
    drain();
    check_val("a16_count", 32'(n_out - n0), 32'd1);

    // 20-base read, full throughput.
    load_read("ACGTTGCAAGCTTACGGATC");
    push_expected();
    n0 = n_out;
    out_cyc.delete();
    send_bases(20, 1'b1, -1);
    drain();
    check_val("r20_count", 32'(n_out - n0), 32'd5);
    if (out_cyc.size() == 5)
      check_val("r20_back2back", 32'(out_cyc[4] - out_cyc[0]), 32'd4);
    else
      check_val("r20_outs", 32'(out_cyc.size()), 32'd5);

    // Same read with a 3-cycle consumer stall mid-stream.
    push_expected();
    n0 = n_out;
    n_wait = 0;
    send_bases(20, 1'b1, 17);
    drain();
    check_val("stall_count", 32'(n_out - n0), 32'd5);
    check_val("stall_waits", 32'(n_wait), 32'd3);

    // Short read then a full read: only the second read emits, starting at pos 0.
    load_read("GATTACAGGC");
    n0 = n_out;
    send_bases(10, 1'b1, -1);
    load_read("CCGTAGGTTACAGTCA");
    push_expected();
    send_bases(16, 1'b1, -1);
    drain();
    check_val("short_count", 32'(n_out - n0), 32'd1);

    // Reset mid-read after 12 bases, then a fresh 16-base read.
    load_read("TTGACCAGTGCA");
    send_bases(12, 1'b0, -1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    load_read("ACGGTCATTGCAGTAC");
    push_expected();
    n0 = n_out;
    send_bases(15, 1'b0, -1);
    @(negedge clk);
    check_val("rst_no_early_out", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    drive_base(rd[15], 1'b1);
    @(negedge clk);
    check_val("rst_first_valid", 32'(out_valid), 32'd1);
    check_val("rst_first_pos", out_pos, 32'd0);
    @(posedge clk); #1;
    drain();
    check_val("rst_count", 32'(n_out - n0), 32'd1);

    // 16 x T: canonical build folds to the all-A hash.
    load_read("TTTTTTTTTTTTTTTT");
    push_expected();
    send_bases(16, 1'b1, -1);
    @(negedge clk);
`ifdef KMER_HASH_CANONICAL_EN
    check_val("t16_h1", out_h1, 32'h330A2514);
`else
    check_val("t16_h1", out_h1, murmur(32'hFFFFFFFF));
`endif
    check_val("t16_last", 32'(out_last), 32'd1);
    @(posedge clk); #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmer_hash_sequencer.md
# kmer_hash_sequencer

Streaming controller that turns a 2-bit nucleotide stream into back-to-back k-mer hash jobs for the combinational murmur `hasher`, which it instantiates internally. It keeps a sliding window of the last `KMER_SIZE` bases and tracks read boundaries. For every complete k-mer it registers `h1`, the bucket index `h2`, the k-mer start position and an end-of-read flag behind a valid/ready output. It sits between the read loader and the bucket-insert logic of the LSH index.

## Interface
- `NUM_OF_BUCKETS`, 256: bucket count, power of two; passed to `hasher`.
- `KMER_SIZE`, 16: window length in bases. Only 16 is supported, because it fills the 32-bit hash chunk.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  base available.
- `in_ready`  out  1  sequencer accepts the base this cycle.
- `in_base`  in  2  nucleotide: A=00, C=01, G=10, T=11.
- `in_last`  in  1  base is the final base of its read.
- `out_valid`  out  1  hash result held.
- `out_ready`  in  1  consumer takes the result.
- `out_h1`  out  32  murmur hash of the k-mer.
- `out_h2`  out  $clog2(NUM_OF_BUCKETS)  bucket index, equal to `out_h1[$clog2(NUM_OF_BUCKETS)-1:0]`.
- `out_pos`  out  32  index of the k-mer's first base within its read, 0-based.
- `out_last`  out  1  k-mer is the last one of its read.

## Operation
- Accept rule: a base is accepted when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, i.e. a single output register with pass-through ready and no skid buffer.
- Window: a 16-entry shift register. An accepted base enters at `kmer[15]`, the newest position; `kmer[0]` is the oldest base. Hash chunk is `{kmer[0],…,kmer[15]}`, so the oldest base lands in bits 31:30.
- FSM states:
  - FILL: `fill_cnt` < 16. Each accepted base increments `fill_cnt`. The 16th base moves the FSM to STREAM and emits a result.
  - STREAM: each accepted base emits a result.
  - Any accepted base with `in_last=1` returns the FSM to FILL with `fill_cnt=0` and `pos_cnt=0` for the next cycle.
- Emission: when an accepted base completes a window, the output register loads:
  - `out_h1`/`out_h2` from the hasher applied to the post-shift window;
  - `out_pos` = `pos_cnt`;
  - `out_last` = `in_last`.
- `pos_cnt` increments on each emission. It is 32-bit and wraps at 2^32 with no flag.
- Short read: `in_last` arriving while `fill_cnt` < 15 before the accept (fewer than 16 bases total) emits nothing. The sequencer silently resets to FILL.
- Output hold: `out_valid` stays high and all `out_*` fields stay stable until `out_ready`.
- Simultaneous `out_ready` and a new emitting accept in the same cycle: the register reloads with the new result and `out_valid` stays 1.
- Reset mid-read discards the window, counters and any pending output.

## Timing
- Reset values: `out_valid=0`, `out_h1=0`, `out_h2=0`, `out_pos=0`, `out_last=0`; FSM=FILL, `fill_cnt=0`, `pos_cnt=0`. `in_ready` is 1 after reset.
- Latency: a base accepted in cycle t produces `out_valid=1` in cycle t+1.
- Throughput: one k-mer per cycle in STREAM with `out_ready` held high.
- The hash is combinational between the window-next value and the output register: one 32×32 multiply chain per cycle, no pipelining.
- `in_ready` is combinational from `out_valid`/`out_ready`. It has no path from `in_valid`.

## Configuration
- `KMER_HASH_CANONICAL_EN` defined:
  - The hashed chunk is min(forward, revcomp) as unsigned 32-bit values.
  - revcomp = base order reversed with each base bitwise-inverted (A↔T, C↔G).
  - Latency and handshake are unchanged.
- Macro undefined: the forward chunk is hashed as-is. No revcomp logic is compiled.

## Test plan
- Reset, then read of 16×A with `in_last` on the 16th base and `out_ready=1` → exactly one output one cycle later: `out_h1=32'h330A2514`, `out_h2=8'h14`, `out_pos=0`, `out_last=1`. The result is identical with `KMER_HASH_CANONICAL_EN`.
- Read of 20 random bases, `out_ready=1` → 5 outputs on consecutive cycles, `out_pos` 0..4, `out_last` only on pos 4. Each `out_h1` matches the murmurblock model with seed `32'h8f83adef`.
- Same read with `out_ready` low for 3 cycles mid-stream → `in_ready=0` while `out_valid=1`, outputs held stable, no k-mer lost or duplicated, `out_pos` sequence still 0..4.
- Read of 10 bases with `in_last` on the 10th, then a 16-base read → no output for the first read; second read emits `out_pos=0`, proving the window and counters were cleared.
- Assert `rst` after 12 bases of a read, then feed 16 bases → the first output appears only after the 16th post-reset base, with `out_pos=0`.
- With `KMER_HASH_CANONICAL_EN`: window 16×T (chunk `32'hFFFFFFFF`) → hashed chunk is 0 and `out_h1=32'h330A2514`. Without the macro, the output equals murmurblock(seed, `32'hFFFFFFFF`).
